// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: IR/memory/datapath control bundle between the control FSM and the datapath
interface multicycle_control_unit_if;
  logic [5:0] opc;
  logic [5:0] func;
  logic zero;
  logic memReady;
  logic pcWrite;
  logic [1:0] pcSrc;
  logic irWrite;
  logic iOrD;
  logic memRead;
  logic memWrite;
  logic aluSrcA;
  logic [1:0] aluSrcB;
  logic [2:0] aluFunc;
  logic bitXtend;
  logic rfWriteEnable;
  logic rfWriteAddrSel;
  logic [1:0] rfWriteDataSel;
  modport master(
    input opc, func, zero, memReady,
    output pcWrite, pcSrc, irWrite, iOrD, memRead, memWrite, aluSrcA, aluSrcB,
           aluFunc, bitXtend, rfWriteEnable, rfWriteAddrSel, rfWriteDataSel
  );
  modport slave(
    output opc, func, zero, memReady,
    input pcWrite, pcSrc, irWrite, iOrD, memRead, memWrite, aluSrcA, aluSrcB,
          aluFunc, bitXtend, rfWriteEnable, rfWriteAddrSel, rfWriteDataSel
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle MIPS32 control FSM with memory timeout, sticky traps and retire counter
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  multicycle_control_unit_if.master bus,
  output logic invOpcode,
  output logic memTimeout,
  output logic [3:0] state,
  output logic [CNT_W-1:0] instrCount
);
  localparam int WW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3, MEM_WB = 4'd4,
    MEM_WRITE = 4'd5, EXECUTE = 4'd6, ALU_WB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, TRAP = 4'd10
  } stateT;
  stateT st;
  logic [WW-1:0] waitCnt;
  logic fValid, immOp, waitState, expired, retire;
  logic [2:0] rFunc;
  assign state = st;
  assign fValid = bus.func inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};
  assign immOp = bus.opc inside {6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F};
  assign rFunc = (bus.func == 6'h20 || bus.func == 6'h21) ? 3'd0 :
                 (bus.func == 6'h22 || bus.func == 6'h23) ? 3'd1 :
                 bus.func == 6'h24 ? 3'd2 :
                 bus.func == 6'h25 ? 3'd3 : 3'd4;
  assign waitState = st inside {FETCH, MEM_READ, MEM_WRITE};
  // A ready on the final allowed wait cycle still completes the access
  assign expired = MEM_TIMEOUT != 0 && waitState && !bus.memReady && waitCnt == WW'(MEM_TIMEOUT);
  assign retire = st inside {ALU_WB, MEM_WB, BRANCH, JUMP} || (st == MEM_WRITE && bus.memReady);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= FETCH;
      waitCnt <= '0;
      instrCount <= '0;
      invOpcode <= 1'b0;
      memTimeout <= 1'b0;
    end else begin
      waitCnt <= (waitState && !bus.memReady && !expired) ? waitCnt + 1'b1 : '0;
      instrCount <= instrCount + CNT_W'(retire);
      if (expired) begin
        st <= TRAP;
        memTimeout <= 1'b1;
      end else begin
        case (st)
          FETCH: if (bus.memReady) st <= DECODE;
          DECODE:
            if ((bus.opc == 6'h00 && fValid) || immOp) st <= EXECUTE;
            else if (bus.opc == 6'h23 || bus.opc == 6'h2B) st <= MEM_ADDR;
            else if (bus.opc == 6'h04 || bus.opc == 6'h05) st <= BRANCH;
            else if (bus.opc == 6'h02) st <= JUMP;
            else begin
              st <= TRAP;
              invOpcode <= 1'b1;
            end
          MEM_ADDR: st <= bus.opc == 6'h23 ? MEM_READ : MEM_WRITE;
          MEM_READ: if (bus.memReady) st <= MEM_WB;
          MEM_WRITE: if (bus.memReady) st <= FETCH;
          EXECUTE: st <= ALU_WB;
          ALU_WB, MEM_WB, BRANCH, JUMP: st <= FETCH;
          default: st <= TRAP;
        endcase
      end
    end
  end
  // Strobes are gated by rst_n so nothing fires while reset is held
  always_comb begin
    bus.pcWrite = 1'b0;
    bus.pcSrc = 2'd0;
    bus.irWrite = 1'b0;
    bus.iOrD = 1'b0;
    bus.memRead = 1'b0;
    bus.memWrite = 1'b0;
    bus.aluSrcA = 1'b0;
    bus.aluSrcB = 2'd0;
    bus.aluFunc = 3'd0;
    bus.bitXtend = 1'b0;
    bus.rfWriteEnable = 1'b0;
    bus.rfWriteAddrSel = 1'b0;
    bus.rfWriteDataSel = 2'd0;
    if (rst_n) begin
      case (st)
        FETCH: begin
          bus.memRead = 1'b1;
          bus.aluSrcB = 2'd1;
          bus.irWrite = bus.memReady;
          bus.pcWrite = bus.memReady;
        end
        DECODE: bus.aluSrcB = 2'd3;
        EXECUTE: begin
          bus.aluSrcA = 1'b1;
          bus.aluSrcB = bus.opc == 6'h00 ? 2'd0 : 2'd2;
          bus.aluFunc = bus.opc == 6'h00 ? rFunc :
                        bus.opc == 6'h0C ? 3'd2 :
                        bus.opc == 6'h0D ? 3'd3 :
                        bus.opc == 6'h0F ? 3'd5 : 3'd0;
          bus.bitXtend = bus.opc == 6'h0C || bus.opc == 6'h0D;
        end
        ALU_WB: begin
          bus.rfWriteEnable = 1'b1;
          bus.rfWriteAddrSel = bus.opc == 6'h00;
        end
        MEM_ADDR: begin
          bus.aluSrcA = 1'b1;
          bus.aluSrcB = 2'd2;
        end
        MEM_READ: begin
          bus.memRead = 1'b1;
          bus.iOrD = 1'b1;
        end
        MEM_WB: begin
          bus.rfWriteEnable = 1'b1;
          bus.rfWriteDataSel = 2'd1;
        end
        MEM_WRITE: begin
          bus.memWrite = 1'b1;
          bus.iOrD = 1'b1;
        end
        BRANCH: begin
          bus.aluSrcA = 1'b1;
          bus.aluFunc = 3'd1;
          bus.pcSrc = 2'd1;
          bus.pcWrite = bus.opc == 6'h05 ? !bus.zero : bus.zero;
        end
        JUMP: begin
          bus.pcSrc = 2'd2;
          bus.pcWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: randomized instruction streams checked against a per-instruction trace model
module tb_multicycle_control_unit;
  typedef struct packed {
    logic [3:0] st;
    logic pcWrite;
    logic [1:0] pcSrc;
    logic irWrite, iOrD, memRead, memWrite, aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluFunc;
    logic bitXtend, rfWe, rfWas;
    logic [1:0] rfWds;
    logic invOp, memTo;
  } ctrlT;
  typedef struct packed {
    logic [1:0] rdy;
    ctrlT c;
  } stepT;
  logic clk = 1'b0;
  logic rstA, rstB, zero, rdy;
  logic [5:0] opc, func;
  logic invA, invB, toA, toB;
  logic [3:0] stA, stB;
  logic [31:0] cntA;
  logic [1:0] cntB;
  ctrlT obsA, obsB;
  stepT q[$];
  int vectors = 0;
  int miscompares = 0;
  int unsigned cnt = 0;
  always #5 clk = ~clk;
  multicycle_control_unit_if busA();
  multicycle_control_unit_if busB();
  assign busA.opc = opc;
  assign busA.func = func;
  assign busA.zero = zero;
  assign busA.memReady = rdy;
  assign busB.opc = opc;
  assign busB.func = func;
  assign busB.zero = zero;
  assign busB.memReady = rdy;
  multicycle_control_unit #(.MEM_TIMEOUT(15), .CNT_W(32)) dutA (
    .clk(clk), .rst_n(rstA), .bus(busA.master), .invOpcode(invA), .memTimeout(toA),
    .state(stA), .instrCount(cntA)
  );
  multicycle_control_unit #(.MEM_TIMEOUT(4), .CNT_W(2)) dutB (
    .clk(clk), .rst_n(rstB), .bus(busB.master), .invOpcode(invB), .memTimeout(toB),
    .state(stB), .instrCount(cntB)
  );
  assign obsA = {stA, busA.pcWrite, busA.pcSrc, busA.irWrite, busA.iOrD, busA.memRead, busA.memWrite,
                 busA.aluSrcA, busA.aluSrcB, busA.aluFunc, busA.bitXtend, busA.rfWriteEnable,
                 busA.rfWriteAddrSel, busA.rfWriteDataSel, invA, toA};
  assign obsB = {stB, busB.pcWrite, busB.pcSrc, busB.irWrite, busB.iOrD, busB.memRead, busB.memWrite,
                 busB.aluSrcA, busB.aluSrcB, busB.aluFunc, busB.bitXtend, busB.rfWriteEnable,
                 busB.rfWriteAddrSel, busB.rfWriteDataSel, invB, toB};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic ctrlT s(input logic [3:0] st);
    ctrlT c = '0;
    c.st = st;
    return c;
  endfunction
  function automatic ctrlT fetchC();
    ctrlT c = s(4'd0);
    c.memRead = 1'b1;
    c.aluSrcB = 2'd1;
    return c;
  endfunction
  task automatic push(input logic [1:0] r, input ctrlT c);
    q.push_back({r, c});
  endtask
  // Cycle-by-cycle expectation for one instruction: rdy 0/1 driven as given, 2 = don't care
  task automatic buildInstr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int wF, input int wM, output bit retires);
    ctrlT c;
    bit rOk = o == 6'h00 && (f inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A});
    bit imm = o inside {6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F};
    retires = 1'b1;
    c = fetchC();
    repeat (wF) push(2'd0, c);
    c.irWrite = 1'b1;
    c.pcWrite = 1'b1;
    push(2'd1, c);
    c = s(4'd1);
    c.aluSrcB = 2'd3;
    push(2'd2, c);
    if (rOk || imm) begin
      c = s(4'd6);
      c.aluSrcA = 1'b1;
      c.aluSrcB = imm ? 2'd2 : 2'd0;
      if (rOk)
        case (f)
          6'h22, 6'h23: c.aluFunc = 3'd1;
          6'h24: c.aluFunc = 3'd2;
          6'h25: c.aluFunc = 3'd3;
          6'h2A: c.aluFunc = 3'd4;
          default: c.aluFunc = 3'd0;
        endcase
      else
        case (o)
          6'h0C: c.aluFunc = 3'd2;
          6'h0D: c.aluFunc = 3'd3;
          6'h0F: c.aluFunc = 3'd5;
          default: c.aluFunc = 3'd0;
        endcase
      c.bitXtend = o == 6'h0C || o == 6'h0D;
      push(2'd2, c);
      c = s(4'd7);
      c.rfWe = 1'b1;
      c.rfWas = rOk;
      push(2'd2, c);
    end else if (o == 6'h23 || o == 6'h2B) begin
      c = s(4'd2);
      c.aluSrcA = 1'b1;
      c.aluSrcB = 2'd2;
      push(2'd2, c);
      c = s(o == 6'h23 ? 4'd3 : 4'd5);
      c.iOrD = 1'b1;
      c.memRead = o == 6'h23;
      c.memWrite = o == 6'h2B;
      repeat (wM) push(2'd0, c);
      push(2'd1, c);
      if (o == 6'h23) begin
        c = s(4'd4);
        c.rfWe = 1'b1;
        c.rfWds = 2'd1;
        push(2'd2, c);
      end
    end else if (o == 6'h04 || o == 6'h05) begin
      c = s(4'd8);
      c.aluSrcA = 1'b1;
      c.aluFunc = 3'd1;
      c.pcSrc = 2'd1;
      c.pcWrite = o == 6'h04 ? z : !z;
      push(2'd2, c);
    end else if (o == 6'h02) begin
      c = s(4'd9);
      c.pcSrc = 2'd2;
      c.pcWrite = 1'b1;
      push(2'd2, c);
    end else begin
      retires = 1'b0;
      c = s(4'd10);
      c.invOp = 1'b1;
      repeat (20) push(2'd2, c);
    end
  endtask
  task automatic runTrace(input bit chkA, input bit chkB);
    stepT e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      rdy = e.rdy == 2'd2 ? 1'($urandom) : e.rdy[0];
      #1;
      if (chkA) begin
        check("ctrlA", 32'(obsA), 32'(e.c));
        check("cntA", cntA, cnt);
      end
      if (chkB) begin
        check("ctrlB", 32'(obsB), 32'(e.c));
        check("cntB", 32'(cntB), cnt % 4);
      end
    end
  endtask
  task automatic doReset();
    @(negedge clk);
    rstA = 1'b0;
    rstB = 1'b0;
    rdy = 1'b1;
    cnt = 0;
    #1;
    check("rstA", 32'(obsA), 32'(0));
    check("rstB", 32'(obsB), 32'(0));
    check("rstCntA", cntA, 0);
    check("rstCntB", 32'(cntB), 0);
    @(posedge clk);
    #2;
    rstA = 1'b1;
    rstB = 1'b1;
  endtask
  task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic z, input int wF, input int wM);
    bit ret;
    opc = o;
    func = f;
    zero = z;
    buildInstr(o, f, z, wF, wM, ret);
    runTrace(1'b1, 1'b1);
    if (ret) cnt++;
    else doReset();
  endtask
  logic [5:0] opcTab [13] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
  logic [5:0] funcTab [7] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};
  initial begin
    ctrlT c;
    logic [5:0] o, f;
    rstA = 1'b0;
    rstB = 1'b0;
    opc = '0;
    func = '0;
    zero = 1'b0;
    rdy = 1'b0;
    doReset();
    instr(6'h00, 6'h20, 1'b0, 0, 0);
    instr(6'h23, 6'h00, 1'b0, 0, 3);
    instr(6'h04, 6'h00, 1'b1, 0, 0);
    instr(6'h05, 6'h00, 1'b1, 0, 0);
    instr(6'h02, 6'h00, 1'b0, 0, 0);
    instr(6'h0D, 6'h00, 1'b0, 1, 0);
    instr(6'h0F, 6'h00, 1'b0, 0, 0);
    instr(6'h2B, 6'h00, 1'b0, 0, 2);
    // Abort a store while its memory request is pending
    opc = 6'h2B;
    push(2'd1, fetchC() | ctrlT'({4'd0, 1'b1, 2'd0, 1'b1, 16'd0}));
    c = s(4'd1); c.aluSrcB = 2'd3; push(2'd2, c);
    c = s(4'd2); c.aluSrcA = 1'b1; c.aluSrcB = 2'd2; push(2'd2, c);
    c = s(4'd5); c.memWrite = 1'b1; c.iOrD = 1'b1; push(2'd0, c); push(2'd0, c);
    runTrace(1'b1, 1'b1);
    doReset();
    instr(6'h00, 6'h25, 1'b0, 0, 0);
    instr(6'h3F, 6'h00, 1'b0, 0, 0);
    instr(6'h00, 6'h27, 1'b0, 0, 0);
    // Fetch timeout on the MEM_TIMEOUT=4 instance
    opc = 6'h00;
    func = 6'h20;
    repeat (5) push(2'd0, fetchC());
    c = s(4'd10); c.memTo = 1'b1;
    repeat (6) push(2'd2, c);
    runTrace(1'b0, 1'b1);
    doReset();
    repeat (4) push(2'd0, fetchC());
    c = fetchC(); c.irWrite = 1'b1; c.pcWrite = 1'b1; push(2'd1, c);
    c = s(4'd1); c.aluSrcB = 2'd3; push(2'd2, c);
    runTrace(1'b0, 1'b1);
    doReset();
    for (int i = 0; i < 150; i++) begin
      o = $urandom_range(0, 99) < 6 ? 6'($urandom) : opcTab[$urandom_range(0, 12)];
      f = $urandom_range(0, 99) < 8 ? 6'($urandom) : funcTab[$urandom_range(0, 6)];
      instr(o, f, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
